cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Synthesizable run controller and register-dump reader for `CPU_64bit`. On `start` it holds the CPU in reset for a fixed number of cycles, then lets it execute for a fixed cycle budget, then freezes it. It then reads every architectural register through a debug read port into `regfile`, streaming each value out over a valid/ready channel. It sits between the CPU and on-chip debug/trace logic, and replaces bench-driven reset sequencing and cycle counting in hardware runs.

## Interface
- `RESET_CYCLES`, 1, cycles `cpu_reset` is held high after `start` (≥1)
- `RUN_CYCLES`, 34, execution cycles granted before freeze (1 … 2^32−1)
- `NUM_REGS`, 32, registers dumped, indices 0 … NUM_REGS−1
- `XLEN`, 64, register width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; honoured only in IDLE or DONE
- `cpu_reset`  out  1  drives CPU `reset`
- `cpu_en`  out  1  CPU clock enable (CPU state advances only when 1)
- `rf_rd_addr`  out  5  debug read address into `regfile`
- `rf_rd_data`  in  XLEN  debug read data, combinational from `rf_rd_addr`
- `dump_valid`  out  1  `dump_idx`/`dump_data` valid
- `dump_ready`  in  1  consumer accepts when high with `dump_valid`
- `dump_idx`  out  5  register index of current beat
- `dump_data`  out  XLEN  register value of current beat
- `cycle_count`  out  32  RUN cycles elapsed in current/last run
- `done`  out  1  high while in DONE

## Operation
- States: IDLE, HOLD, RUN, LOAD, SEND, DONE.
- Reset values: state IDLE; `cpu_reset`=1, `cpu_en`=0, `rf_rd_addr`=0, `dump_valid`=0, `dump_idx`=0, `dump_data`=0, `cycle_count`=0, `done`=0.
- IDLE: `cpu_reset`=1, `cpu_en`=0. On `start` → HOLD. Clear `cycle_count` and the hold counter.
- HOLD: `cpu_reset`=1, `cpu_en`=1. After RESET_CYCLES cycles → RUN.
- RUN: `cpu_reset`=0, `cpu_en`=1. `cycle_count` increments by 1 each cycle. It stops at RUN_CYCLES, then → LOAD with `rf_rd_addr`=0.
- LOAD: `cpu_en`=0. Capture `rf_rd_data` into `dump_data` and `rf_rd_addr` into `dump_idx` → SEND.
- SEND: `dump_valid`=1. Hold `dump_idx`/`dump_data` stable until `dump_valid && dump_ready`.
  - On handshake with `dump_idx`=NUM_REGS−1 → DONE.
  - On any other handshake, increment `rf_rd_addr` → LOAD.
- DONE: `done`=1, `cpu_reset`=0, `cpu_en`=0. CPU state is frozen and readable. On `start` → HOLD (restart, counters cleared).
- `start` is ignored in HOLD/RUN/LOAD/SEND.
- `cpu_en`=0 in LOAD/SEND/DONE. The CPU PC and regfile must not change, so the dump is a consistent snapshot.
- `reset` in any state: next edge forces reset values. An in-flight beat is dropped (`dump_valid` low after that edge, no completion).

## Timing
- All outputs registered; no combinational path from `dump_ready` or `start` to any output.
- Latency `start` → first `cpu_reset`=0 cycle: 1 + RESET_CYCLES edges.
- The CPU receives exactly RUN_CYCLES enabled cycles with `cpu_reset`=0.
- The first `dump_valid` rises 2 cycles after the last RUN cycle (LOAD, then SEND).
- Throughput: one beat per 2 cycles with `dump_ready` tied high. Full dump is 2·NUM_REGS cycles minimum.
- Backpressure of any length is legal; data stays stable for its whole duration.
- `done` rises the cycle after the final handshake.

## Structure
- Shared package `cpu_dbg_pkg`: state enum `run_state_t`, `XLEN`=64, `REG_COUNT`=32, `REG_ADDR_W`=5.
- One sub-module, `run_counter`: a 32-bit counter with clear, enable, and terminal-value compare. Instantiated twice, once for HOLD and once for RUN.
- Integration adds a debug read port to `regfile`, muxed in while `cpu_en`=0.

## Test plan
- Default params, `dump_ready`=1, pulse `start` → `cpu_reset` high 1 enabled cycle, then exactly 34 RUN cycles, `cycle_count`=34; 32 beats with `dump_idx` 0…31 in order; `done`=1 65 cycles after RUN ends.
- Preload regfile X5=0xDEADBEEF_00000005, X31=0 → beat 5 data 0xDEADBEEF_00000005, beat 31 data 0.
- Random `dump_ready` stalls up to 7 cycles → every beat data/idx stable while stalled, no beat lost or duplicated.
- `start` pulsed during RUN and SEND → ignored: `cycle_count` still ends at 34, dump completes normally.
- `reset` asserted mid-dump at beat 10 → next cycle IDLE, `dump_valid`=0, `cpu_reset`=1. A new `start` yields a full dump from index 0.
- From DONE, pulse `start` → `done` drops, `cycle_count` restarts at 0, and a second full run/dump completes.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU run controller and its debug dump path.
package cpu_dbg_pkg;

    localparam int XLEN       = 64;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_LOAD = 3'd3,
        ST_SEND = 3'd4,
        ST_DONE = 3'd5
    } run_state_t;

    // Debug view of the controller: FSM state plus the reset-hold progress.
    typedef struct packed {
        run_state_t       state;
        logic [CNT_W-1:0] hold_count;
    } dbg_t;

    function automatic logic cpu_enabled(input run_state_t s);
        return (s == ST_HOLD) || (s == ST_RUN);
    endfunction

    function automatic logic cpu_in_reset(input run_state_t s);
        return (s == ST_IDLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/run_counter.sv
// Cycle counter with synchronous clear, count enable and a terminal-value compare.
module run_counter
    import cpu_dbg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // High during the enabled cycle that brings count up to term.
    assign hit = en && (count == (term - CNT_W'(1)));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences CPU reset and a fixed run budget, then freezes the CPU and streams
// every architectural register out over a valid/ready channel.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_CYCLES = 32'd1,
    parameter logic [CNT_W-1:0] RUN_CYCLES   = 32'd34,
    parameter int               NUM_REGS     = REG_COUNT
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  cpu_reset,
    output logic                  cpu_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [XLEN-1:0]       rf_rd_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [REG_ADDR_W-1:0] dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic [CNT_W-1:0]      cycle_count,
    output logic                  done,
    output dbg_t                  dbg
);

    // Dump channel: a beat transfers on a rising edge where dump_valid and
    // dump_ready are both high; dump_idx/dump_data hold until that edge.

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    run_state_t            state, state_nxt;
    logic [REG_ADDR_W-1:0] rd_addr_nxt, idx_nxt;
    logic [XLEN-1:0]       data_nxt;
    logic                  cnt_clr, hold_hit, run_hit;
    logic [CNT_W-1:0]      hold_count;

    assign cnt_clr = (state == ST_IDLE) || ((state == ST_DONE) && start);

    run_counter u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (state == ST_HOLD),
        .term  (RESET_CYCLES),
        .count (hold_count),
        .hit   (hold_hit)
    );

    run_counter u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (state == ST_RUN),
        .term  (RUN_CYCLES),
        .count (cycle_count),
        .hit   (run_hit)
    );

    assign dbg = '{state: state, hold_count: hold_count};

    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rf_rd_addr;
        idx_nxt     = dump_idx;
        data_nxt    = dump_data;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_HOLD;
            ST_HOLD: if (hold_hit) state_nxt = ST_RUN;
            ST_RUN: begin
                if (run_hit) begin
                    state_nxt   = ST_LOAD;
                    rd_addr_nxt = '0;
                end
            end
            ST_LOAD: begin
                idx_nxt   = rf_rd_addr;
                data_nxt  = rf_rd_data;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        rd_addr_nxt = rf_rd_addr + REG_ADDR_W'(1);
                        state_nxt   = ST_LOAD;
                    end
                end
            end
            ST_DONE: if (start) state_nxt = ST_HOLD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_reset  <= 1'b1;
            cpu_en     <= 1'b0;
            rf_rd_addr <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_reset  <= cpu_in_reset(state_nxt);
            cpu_en     <= cpu_enabled(state_nxt);
            rf_rd_addr <= rd_addr_nxt;
            dump_valid <= (state_nxt == ST_SEND);
            dump_idx   <= idx_nxt;
            dump_data  <= data_nxt;
            done       <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with a tiny stand-in CPU whose X1 counts run cycles.
module tb_cpu_run_ctrl;
    import cpu_dbg_pkg::*;

    localparam int W = REG_ADDR_W + XLEN;

    logic                  clk = 1'b0;
    logic                  reset, start, dump_ready;
    logic                  cpu_reset, cpu_en, dump_valid, done;
    logic [REG_ADDR_W-1:0] rf_rd_addr, dump_idx;
    logic [XLEN-1:0]       rf_rd_data, dump_data;
    logic [CNT_W-1:0]      cycle_count;
    dbg_t                  dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int checks = 0;
    int failures = 0;

    // Monitor bookkeeping, counted in negedge samples.
    int n = 0, run_seen = 0, last_run_n = 0, first_valid_n = 0, done_n = 0;
    bit valid_seen = 0, done_seen = 0, prev_stall = 0;
    logic [REG_ADDR_W-1:0] prev_idx;
    logic [XLEN-1:0]       prev_data;
    logic [XLEN-1:0]       x1 = 64'hFFFF_FFFF_FFFF_FFFF;

    cpu_run_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .cycle_count(cycle_count),
        .done       (done),
        .dbg        (dbg)
    );

    // ---------------- clock / stand-in CPU ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_en) x1 <= cpu_reset ? 64'd0 : x1 + 64'd1;
    end

    function automatic logic [XLEN-1:0] rf_init(input int i);
        if (i == 0 || i == 31) return 64'd0;
        if (i == 5) return 64'hDEADBEEF_00000005;
        return {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    assign rf_rd_data = (rf_rd_addr == 5'd1) ? x1 : rf_init(int'(rf_rd_addr));

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_expected();
        logic [XLEN-1:0] d;
        for (int i = 0; i < REG_COUNT; i++) begin
            case (i)
                1:       d = 64'd34;
                5:       d = 64'hDEADBEEF_00000005;
                31:      d = 64'd0;
                default: d = rf_init(i);
            endcase
            exp_q.push_back({REG_ADDR_W'(i), d});
        end
    endtask

    // mode 0: ready high; 1: random stalls; 2: ready high + stray starts; 3: reset at beat 10
    task automatic run_full(input int mode);
        int  k;
        int  stall_left;
        bit  finished;
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_done_low", done, 0);
        chk("start_count_clear", cycle_count, 0);
        chk("hold_cpu_reset", cpu_reset, 1);
        chk("hold_cpu_en", cpu_en, 1);
        k = 1;
        while (cpu_reset && k < 20) begin
            tick();
            k++;
        end
        chk("start_latency", k, 2);
        finished   = 0;
        stall_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin
                finished = 1;
                break;
            end
            start = 1'b0;
            case (mode)
                1: begin
                    if (stall_left > 0) begin
                        dump_ready = 1'b0;
                        stall_left--;
                    end else begin
                        dump_ready = 1'b1;
                        stall_left = $urandom_range(0, 7);
                    end
                end
                2: begin
                    if (cpu_en && !cpu_reset && cycle_count == 32'd10) start = 1'b1;
                    if (dump_valid && dump_idx == 5'd7) start = 1'b1;
                end
                3: begin
                    if (dump_valid && dump_idx == 5'd10) begin
                        dump_ready = 1'b0;
                        reset = 1'b1;
                        tick();
                        reset = 1'b0;
                        dump_ready = 1'b1;
                        chk("rst_dump_valid", dump_valid, 0);
                        chk("rst_cpu_reset", cpu_reset, 1);
                        chk("rst_cpu_en", cpu_en, 0);
                        chk("rst_done", done, 0);
                        chk("rst_cycle_count", cycle_count, 0);
                        chk("rst_state", dbg.state, ST_IDLE);
                        chk("rst_beats_pending", exp_q.size(), 22);
                        exp_q.delete();
                        return;
                    end
                end
                default: ;
            endcase
            tick();
        end
        start = 1'b0;
        dump_ready = 1'b1;
        if (!finished || mode == 3) begin
            checks++;
            failures++;
            $display("FAIL run_end mode=%0d actual done=%0b expected run to %s", mode, done,
                     (mode == 3) ? "reach beat 10" : "finish");
            exp_q.delete();
            return;
        end
        @(negedge clk);
        #1;
        chk("run_cycles", run_seen, 34);
        chk("cycle_count", cycle_count, 34);
        chk("valid_gap", first_valid_n - last_run_n, 2);
        if (mode != 1) chk("done_gap", done_n - last_run_n, 65);
        chk("beats_left", exp_q.size(), 0);
        chk("done_state", dbg.state, ST_DONE);
        chk("done_cpu_en", cpu_en, 0);
        chk("done_cpu_reset", cpu_reset, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        n++;
        if (cpu_en && cpu_reset) begin
            run_seen   = 0;
            valid_seen = 0;
            done_seen  = 0;
        end
        if (cpu_en && !cpu_reset) begin
            run_seen++;
            last_run_n = n;
        end
        if (dump_valid && !valid_seen) begin
            valid_seen    = 1;
            first_valid_n = n;
        end
        if (done && !done_seen) begin
            done_seen = 1;
            done_n    = n;
        end
        if (prev_stall) begin
            checks++;
            if (!dump_valid || dump_idx !== prev_idx || dump_data !== prev_data) begin
                failures++;
                $display("FAIL stall_hold actual valid=%0b idx=%0d data=%h expected valid=1 idx=%0d data=%h",
                         dump_valid, dump_idx, dump_data, prev_idx, prev_data);
            end
        end
        if (dump_valid && dump_ready && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_extra actual idx=%0d data=%h expected no beat", dump_idx, dump_data);
            end else begin
                e = exp_q.pop_front();
                if ({dump_idx, dump_data} !== e) begin
                    failures++;
                    $display("FAIL beat actual idx=%0d data=%h expected idx=%0d data=%h",
                             dump_idx, dump_data, e[W-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
        prev_stall = dump_valid && !dump_ready && !reset;
        prev_idx   = dump_idx;
        prev_data  = dump_data;
    end

    // ---------------- main sequence / report ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        dump_ready = 1'b1;
        tick();
        tick();
        chk("reset_state", dbg.state, ST_IDLE);
        chk("reset_cpu_reset", cpu_reset, 1);
        chk("reset_cpu_en", cpu_en, 0);
        chk("reset_rd_addr", rf_rd_addr, 0);
        chk("reset_dump_valid", dump_valid, 0);
        chk("reset_dump_idx", dump_idx, 0);
        chk("reset_dump_data", dump_data, 0);
        chk("reset_cycle_count", cycle_count, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        tick();
        chk("idle_cpu_reset", cpu_reset, 1);
        run_full(0);
        run_full(0);
        run_full(1);
        run_full(2);
        run_full(3);
        run_full(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
